sequenciador_notas: RTL and testbench

Melody sequencer that drives the note/tone display decoder. It holds a small writable table of notes, each with a tone bit, a 3-bit note code and a duration. On start it steps through the table, presenting one `{TOM, NOTAS}` pair at a time for a programmed number of prescaled ticks, with optional looping. Its `TOM`/`NOTAS` outputs connect directly to the decoder's `TOM_module`/`NOTAS` inputs.

---
 rtl/seq_notas_pkg.sv | 27 ++
 rtl/sequenciador_notas_gerador_tick.sv | 29 ++
 rtl/sequenciador_notas.sv | 158 +++++++++++++++
 tb/tb_sequenciador_notas.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_notas_pkg.sv
// Shared types and entry-layout helpers for the melody sequencer.
// An entry is {tom, nota[2:0], dur[DUR_W-1:0]}, MSB first.
package seq_notas_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam int NOTA_W    = 3;
  localparam int DUR_W_DEF = 4;
  localparam int ENTRY_W   = 1 + NOTA_W + DUR_W_DEF;
  localparam int DUR_LSB   = 0;

  function automatic int entry_w(input int dur_w);
    return 1 + NOTA_W + dur_w;
  endfunction

  function automatic int nota_lsb(input int dur_w);
    return dur_w;
  endfunction

  function automatic int tom_bit(input int dur_w);
    return dur_w + NOTA_W;
  endfunction

endpackage

// File: rtl/sequenciador_notas_gerador_tick.sv
// Prescaler: one-cycle tick on the last clock of every PRESCALE-cycle window.
// A synchronous clear restarts the window at count zero.
module gerador_tick #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/sequenciador_notas.sv
// Melody sequencer: steps through a writable note table and presents each
// {TOM, NOTAS} pair for (dur+1) prescaled ticks, with optional looping.
module sequenciador_notas
  import seq_notas_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PRESCALE = 4,
  parameter int DUR_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [2:0]                wr_addr,
  input  logic [NOTA_W+DUR_W:0]     wr_data,
  input  logic [3:0]                length,
  input  logic                      loop,
  input  logic                      start,
  input  logic                      stop,
  output logic                      busy,
  output logic                      done,
  output logic                      TOM,
  output logic [2:0]                NOTAS
);

  localparam int EW = entry_w(DUR_W);
  localparam int TB = tom_bit(DUR_W);
  localparam int NB = nota_lsb(DUR_W);
  localparam logic [2:0] AMASK  = 3'(DEPTH - 1);
  localparam logic [3:0] DEPTH4 = 4'(DEPTH);

  logic [EW-1:0]    tbl [DEPTH];
  state_t           state_q, state_d;
  logic [2:0]       idx_q;
  logic [3:0]       len_q;
  logic             loop_q;
  logic [DUR_W-1:0] dcnt_q, dur_q;
  logic             tom_q;
  logic [2:0]       nota_q;
  logic             done_q;

  logic             tick;
  logic             ld_first, ld_next, go_idle, fin;
  logic             last, expire;
  logic [2:0]       nidx;
  logic [3:0]       len_c;
  logic [EW-1:0]    ent;

  // Prescaler is held cleared while idle so the first window starts at the start edge.
  gerador_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  always_comb begin
    len_c  = (length > DEPTH4) ? DEPTH4 : length;
    last   = ({1'b0, idx_q} == (len_q - 4'd1));
    nidx   = last ? 3'd0 : (idx_q + 3'd1);
    expire = tick && (dcnt_q == dur_q);
    ent    = tbl[(ld_first ? 3'd0 : nidx) & AMASK];
  end

  always_comb begin
    state_d  = state_q;
    ld_first = 1'b0;
    ld_next  = 1'b0;
    go_idle  = 1'b0;
    fin      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (length != 4'd0)) begin
          state_d  = PLAY;
          ld_first = 1'b1;
        end
      end
      PLAY: begin
        // Abort outranks entry expiry on the same edge.
        if (stop) begin
          state_d = IDLE;
          go_idle = 1'b1;
        end else if (expire) begin
          if (last && !loop_q) begin
            state_d = IDLE;
            go_idle = 1'b1;
            fin     = 1'b1;
          end else begin
            ld_next = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      len_q  <= '0;
      loop_q <= 1'b0;
      dcnt_q <= '0;
      dur_q  <= '0;
      tom_q  <= 1'b0;
      nota_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (ld_first) begin
        len_q  <= len_c;
        loop_q <= loop;
        idx_q  <= 3'd0;
      end
      if (ld_first || ld_next) begin
        tom_q  <= ent[TB];
        nota_q <= ent[TB-1:NB];
        dur_q  <= ent[DUR_W-1:0];
        dcnt_q <= '0;
        if (ld_next) begin
          idx_q <= nidx;
        end
      end else if (go_idle) begin
        tom_q  <= 1'b0;
        nota_q <= '0;
        dur_q  <= '0;
        dcnt_q <= '0;
      end else if ((state_q == PLAY) && tick) begin
        dcnt_q <= dcnt_q + 1'b1;
      end
    end
  end

  // Loads read the pre-write contents when address and edge coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else if (wr_en) begin
      tbl[wr_addr & AMASK] <= wr_data;
    end
  end

  assign busy  = (state_q == PLAY);
  assign done  = done_q;
  assign TOM   = tom_q;
  assign NOTAS = nota_q;

endmodule

// File: tb/tb_sequenciador_notas.sv
// Directed and randomized bench for sequenciador_notas against a
// countdown-based reference model of the playback timeline.
module tb_sequenciador_notas;

  localparam int P = 4;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] length;
  logic       loop;
  logic       start;
  logic       stop;
  logic       busy;
  logic       done;
  logic       TOM;
  logic [2:0] NOTAS;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining cycles of the current entry, counted down per edge.
  logic [7:0] m_tbl [8];
  bit         m_play;
  bit         m_done;
  bit         m_loop;
  bit         m_tom;
  logic [2:0] m_nota;
  int         m_idx;
  int         m_len;
  int         m_rem;

  sequenciador_notas #(
    .DEPTH   (8),
    .PRESCALE(P),
    .DUR_W   (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .length (length),
    .loop   (loop),
    .start  (start),
    .stop   (stop),
    .busy   (busy),
    .done   (done),
    .TOM    (TOM),
    .NOTAS  (NOTAS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_tbl[i] = 8'h00;
    m_play = 0; m_done = 0; m_loop = 0; m_tom = 0;
    m_nota = 3'd0; m_idx = 0; m_len = 0; m_rem = 0;
  endtask

  task automatic model_load(input int i);
    logic [7:0] e;
    e      = m_tbl[i];
    m_tom  = e[7];
    m_nota = e[6:4];
    m_rem  = (int'(e[3:0]) + 1) * P;
  endtask

  task automatic model_edge();
    m_done = 0;
    if (!m_play) begin
      if (start && (length != 4'd0)) begin
        m_len  = (int'(length) > 8) ? 8 : int'(length);
        m_loop = loop;
        m_idx  = 0;
        model_load(0);
        m_play = 1;
      end
    end else if (stop) begin
      m_play = 0; m_tom = 0; m_nota = 3'd0;
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_idx == m_len - 1) begin
          if (m_loop) begin
            m_idx = 0;
            model_load(0);
          end else begin
            m_play = 0; m_tom = 0; m_nota = 3'd0; m_done = 1;
          end
        end else begin
          m_idx++;
          model_load(m_idx);
        end
      end
    end
    if (wr_en) m_tbl[wr_addr] = wr_data;
  endtask

  task automatic chk_all();
    chk("busy", 8'(busy), 8'(m_play));
    chk("done", 8'(done), 8'(m_done));
    chk("tom", 8'(TOM), 8'(m_tom));
    chk("notas", 8'(NOTAS), 8'(m_nota));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_edge();
    chk_all();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [3:0] len, input logic lp);
    length = len; loop = lp; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic basic_table();
    wr(3'd0, 8'b0_001_0000);
    wr(3'd1, 8'b1_010_0001);
    wr(3'd2, 8'b0_111_0000);
  endtask

  initial begin
    logic [7:0] d;
    logic [31:0] r;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
    length = 4'd0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_done", 8'(done), 8'h00);
    chk("rst_tom", 8'(TOM), 8'h00);
    chk("rst_notas", 8'(NOTAS), 8'h00);
    #20 rst_n = 1'b1;
    cyc();

    // Reset in the middle of an entry
    wr(3'd0, 8'b1_101_0011);
    go(4'd1, 1'b0);
    chk("mid_first_notas", 8'(NOTAS), 8'h05);
    repeat (5) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 8'(busy), 8'h00);
    chk("mid_rst_tom", 8'(TOM), 8'h00);
    chk("mid_rst_notas", 8'(NOTAS), 8'h00);
    model_reset();
    #3 rst_n = 1'b1;
    go(4'd1, 1'b0);
    chk("post_rst_busy", 8'(busy), 8'h01);
    chk("post_rst_notas", 8'(NOTAS), 8'h00);
    repeat (6) cyc();

    // Basic three-entry sequence
    basic_table();
    go(4'd3, 1'b0);
    chk("basic_e0", 8'(NOTAS), 8'h01);
    repeat (4) cyc();
    chk("basic_e4_notas", 8'(NOTAS), 8'h02);
    chk("basic_e4_tom", 8'(TOM), 8'h01);
    repeat (11) cyc();
    chk("basic_e15", 8'(NOTAS), 8'h07);
    cyc();
    chk("basic_e16_done", 8'(done), 8'h01);
    chk("basic_e16_busy", 8'(busy), 8'h00);
    cyc();
    chk("basic_e17_done", 8'(done), 8'h00);

    // Looping, then stop
    go(4'd3, 1'b1);
    repeat (16) cyc();
    chk("loop_e16_notas", 8'(NOTAS), 8'h01);
    chk("loop_e16_done", 8'(done), 8'h00);
    repeat (4) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("loop_stop_busy", 8'(busy), 8'h00);
    chk("loop_stop_done", 8'(done), 8'h00);
    cyc();

    // Zero length is ignored
    go(4'd0, 1'b0);
    chk("len0_busy", 8'(busy), 8'h00);
    repeat (3) cyc();

    // Over-long length clamps to the table depth
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      d = {r[3:0], 4'b0000};
      wr(3'(i), d);
    end
    go(4'd15, 1'b0);
    repeat (31) cyc();
    chk("len15_e31_busy", 8'(busy), 8'h01);
    cyc();
    chk("len15_e32_done", 8'(done), 8'h01);
    chk("len15_e32_busy", 8'(busy), 8'h00);
    cyc();

    // Stop on the expiry edge of the last entry
    basic_table();
    go(4'd1, 1'b0);
    repeat (3) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stopexp_busy", 8'(busy), 8'h00);
    chk("stopexp_done", 8'(done), 8'h00);
    cyc();
    chk("stopexp_done2", 8'(done), 8'h00);

    // Start and stop together while idle: start wins
    length = 4'd2; loop = 1'b0; start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 8'(busy), 8'h01);
    repeat (14) cyc();

    // Overwrite the entry currently playing
    go(4'd3, 1'b1);
    repeat (4) cyc();
    wr(3'd1, 8'b1_011_0001);
    chk("wrplay_hold", 8'(NOTAS), 8'h02);
    repeat (15) cyc();
    chk("wrplay_new", 8'(NOTAS), 8'h03);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();

    // Randomized rounds
    for (int rnd = 0; rnd < 8; rnd++) begin
      for (int i = 0; i < 8; i++) begin
        r = $urandom;
        d = r[7:0] & 8'hF3;
        wr(3'(i), d);
      end
      r = $urandom;
      go(r[3:0], r[4]);
      for (int c = 0; c < 60; c++) begin
        r = $urandom;
        wr_en   = (r[2:0] == 3'd0);
        wr_addr = r[10:8];
        wr_data = r[23:16] & 8'hF3;
        stop    = (r[29:24] == 6'd0);
        start   = (r[31:30] == 2'd0) && (r[4:3] == 2'd0);
        length  = r[7:4];
        cyc();
      end
      wr_en = 1'b0; start = 1'b0; stop = 1'b1;
      cyc();
      stop = 1'b0;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
